spi_cs_sequencer: RTL and testbench
===================================

Name: spi_cs_sequencer

Overview:
- Multi-byte SPI transaction sequencer that sits directly upstream of spi_transceiver.
- Owns the chip-select with setup, hold and idle timing. Pulls bytes from an upstream byte source and feeds them one at a time to the transceiver.
- Returns each received byte with its index and signals transaction end.
- Typical use: nRF24L01 command byte plus up to 32 payload bytes under a single CS_n low window.

Parameters:
- MAX_BYTES, 33, maximum bytes per transaction; a larger i_Len is clamped to this value.
- CS_SETUP_CLKS, 2, i_Clk cycles from CS_n falling to the first o_Xcv_TX_DV (must be >= 1).
- CS_HOLD_CLKS, 2, i_Clk cycles from the last byte's i_Xcv_RX_DV to CS_n rising (must be >= 1).
- CS_IDLE_CLKS, 2, minimum i_Clk cycles CS_n stays high before o_Busy drops (must be >= 1).
- LW, $clog2(MAX_BYTES+1), width of the length and index fields (derived, not overridden).

Ports:
- i_Clk  in  1  system clock
- i_Rst_L  in  1  reset, asynchronous, active-low
- i_Start  in  1  1-cycle pulse that starts a transaction
- i_Len  in  LW  byte count, sampled with i_Start
- o_Busy  out  1  high from the cycle after an accepted start until the idle gap ends
- i_Src_Byte  in  8  next TX byte from upstream
- i_Src_Valid  in  1  i_Src_Byte is valid; upstream holds it until acked
- o_Src_Ack  out  1  1-cycle pulse: byte consumed; upstream advances
- o_Rx_Byte  out  8  received byte
- o_Rx_Idx  out  LW  index of o_Rx_Byte within the transaction, starting at 0
- o_Rx_DV  out  1  1-cycle pulse: o_Rx_Byte and o_Rx_Idx are valid
- o_Done  out  1  1-cycle pulse coincident with CS_n rising
- o_Xcv_TX_Byte  out  8  to transceiver i_TX_Byte
- o_Xcv_TX_DV  out  1  to transceiver i_TX_DV
- i_Xcv_TX_Ready  in  1  from transceiver o_TX_Ready
- i_Xcv_RX_DV  in  1  from transceiver o_RX_DV
- i_Xcv_RX_Byte  in  8  from transceiver o_RX_Byte
- o_SPI_CS_n  out  1  chip select, active-low

Behaviour:
- Clock and reset:
  - One clock, i_Clk. Reset i_Rst_L is asynchronous, active-low. All outputs are registered.
- Reset values:
  - o_SPI_CS_n = 1.
  - o_Busy, o_Src_Ack, o_Rx_DV, o_Done, o_Xcv_TX_DV = 0.
  - o_Rx_Byte, o_Xcv_TX_Byte = 8'h00; o_Rx_Idx = 0. State = IDLE.
- Reset mid-transaction: CS_n goes high immediately (asynchronous). No o_Done is issued. A byte in flight in the transceiver is abandoned.
- FSM states: IDLE, SETUP, LOAD, XFER, HOLD, GAP. One shared down-counter serves SETUP, HOLD and GAP.
- IDLE:
  - On i_Start with i_Len != 0: latch min(i_Len, MAX_BYTES) as remaining, clear the index, go to SETUP.
  - On the next edge, CS_n=0 and o_Busy=1.
  - i_Start with i_Len == 0 is ignored: no CS activity, no o_Done.
- SETUP: count CS_SETUP_CLKS cycles with CS_n low, then go to LOAD.
- LOAD:
  - Wait until i_Src_Valid=1 and i_Xcv_TX_Ready=1 are both true.
  - On that edge: o_Xcv_TX_DV=1 for exactly 1 cycle, o_Xcv_TX_Byte=i_Src_Byte, o_Src_Ack=1 for exactly 1 cycle. Go to XFER.
  - If i_Src_Valid is low, stall indefinitely with CS_n held low and no SPI clocks.
- XFER:
  - Ignore i_Xcv_TX_Ready. Wait for i_Xcv_RX_DV.
  - On it: register o_Rx_Byte=i_Xcv_RX_Byte and o_Rx_Idx=index, pulse o_Rx_DV, increment index, decrement remaining.
  - If remaining was 1, go to HOLD; otherwise go to LOAD.
- HOLD: count CS_HOLD_CLKS cycles. On exit edge: CS_n=1 and o_Done=1 (1 cycle). Go to GAP.
- GAP: count CS_IDLE_CLKS cycles with CS_n high, then go to IDLE with o_Busy=0.
- i_Start while o_Busy=1 (or in its acceptance cycle): ignored, no queueing.
- Spurious i_Xcv_RX_DV in IDLE, SETUP, LOAD, HOLD or GAP: ignored.
- Counters saturate and never wrap. The index width LW covers 0..MAX_BYTES.
- Latency: with i_Start at cycle 0, CS_n falls at cycle 1, and the earliest first o_Xcv_TX_DV is at cycle 1+CS_SETUP_CLKS.
- Back-to-back bytes: the next DV is issued no earlier than the cycle in which the transceiver re-asserts TX_Ready after RX_DV. CS_n never toggles between bytes.

Decomposition:
- Shared header spi_defs.vh holds:
  - state encodings (3-bit localparams);
  - NRF_MAX_PAYLOAD=32;
  - default CS timing constants.
- No sub-module: the timer and FSM stay inline.
- The next level wrapper, nrf_spi_master, instantiates spi_cs_sequencer plus spi_transceiver and connects the Xcv ports.

Test Plan:
1. Reset, then i_Start with i_Len=1 and Src=8'hA5 with a looped-back transceiver: CS_n low at cycle 1, DV at cycle 3; one o_Rx_DV with Byte=8'hA5 and Idx=0; o_Done at the CS_n rise; o_Busy low CS_IDLE_CLKS later.
2. i_Len=3 with Src bytes 8'h20, 8'h11, 8'h22 and MISO returning 8'h0E, 8'hFF, 8'h00: exactly 3 DV/Ack pairs; Rx Idx 0,1,2 with matching bytes; CS_n held low continuously throughout.
3. i_Src_Valid deasserted for 50 cycles before byte 2: CS_n stays low, no o_Xcv_TX_DV, no SPI clocks; transfer resumes when Valid returns.
4. i_Len=0, then i_Len=40 with MAX_BYTES=33: first produces no CS activity; second produces exactly 33 bytes, then o_Done.
5. Second i_Start pulsed during byte 1 of an i_Len=2 transaction: ignored; exactly 2 bytes and one o_Done.
6. i_Rst_L asserted mid-XFER: CS_n=1 and all pulse outputs 0 asynchronously; a fresh i_Start after release completes normally.

Source files
------------

// File: rtl/spi_cs_sequencer_pkg.sv
// ============================================================================
// Module   : spi_cs_sequencer_pkg
// Purpose  : Shared types and constants for the SPI chip-select sequencer.
//            Holds the FSM state encoding, nRF24L01 payload limit, default
//            CS timing constants and the timer preset helper.
// Ports    : none (package)
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package spi_cs_sequencer_pkg;

  // Sequencer states, 3-bit encoding.
  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_SETUP = 3'd1,
    ST_LOAD  = 3'd2,
    ST_XFER  = 3'd3,
    ST_HOLD  = 3'd4,
    ST_GAP   = 3'd5
  } state_t;

  // nRF24L01: one command byte plus up to 32 payload bytes.
  localparam int NRF_MAX_PAYLOAD   = 32;
  localparam int DEF_MAX_BYTES     = NRF_MAX_PAYLOAD + 1;

  // Default chip-select timing, in clock cycles.
  localparam int DEF_CS_SETUP_CLKS = 2;
  localparam int DEF_CS_HOLD_CLKS  = 2;
  localparam int DEF_CS_IDLE_CLKS  = 2;

  // Width of the shared SETUP/HOLD/GAP down-counter.
  localparam int TMR_W = 8;

  // Timer preset: the number of cycles still to be spent in a timed state,
  // after subtracting the cycles that the surrounding transitions already
  // account for. Never goes below zero.
  function automatic logic [TMR_W-1:0] tmr_preset(input int clks, input int used);
    int v;
    v = clks - used;
    if (v < 0) begin
      v = 0;
    end
    return TMR_W'(v);
  endfunction

endpackage : spi_cs_sequencer_pkg

`default_nettype wire

// File: rtl/spi_cs_sequencer.sv
// ============================================================================
// Module   : spi_cs_sequencer
// Purpose  : Multi-byte SPI transaction sequencer placed directly upstream of
//            an SPI byte transceiver. Owns CS_n with setup/hold/idle timing,
//            pulls TX bytes from an upstream source one at a time, and returns
//            each received byte tagged with its index.
// Ports    :
//   i_Clk, i_Rst_L              clock, async active-low reset
//   i_Start, i_Len, o_Busy      transaction request / status
//   i_Src_Byte, i_Src_Valid,
//   o_Src_Ack                   upstream TX byte source handshake
//   o_Rx_Byte, o_Rx_Idx, o_Rx_DV received byte stream
//   o_Done                      end-of-transaction pulse (with CS_n rising)
//   o_Xcv_TX_Byte, o_Xcv_TX_DV,
//   i_Xcv_TX_Ready, i_Xcv_RX_DV,
//   i_Xcv_RX_Byte               transceiver byte interface
//   o_SPI_CS_n                  chip select, active-low
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module spi_cs_sequencer
  import spi_cs_sequencer_pkg::*;
#(
  parameter  int MAX_BYTES     = DEF_MAX_BYTES,
  parameter  int CS_SETUP_CLKS = DEF_CS_SETUP_CLKS,
  parameter  int CS_HOLD_CLKS  = DEF_CS_HOLD_CLKS,
  parameter  int CS_IDLE_CLKS  = DEF_CS_IDLE_CLKS,
  localparam int LW            = $clog2(MAX_BYTES + 1)
) (
  input  logic          i_Clk,
  input  logic          i_Rst_L,
  input  logic          i_Start,
  input  logic [LW-1:0] i_Len,
  output logic          o_Busy,
  input  logic [7:0]    i_Src_Byte,
  input  logic          i_Src_Valid,
  output logic          o_Src_Ack,
  output logic [7:0]    o_Rx_Byte,
  output logic [LW-1:0] o_Rx_Idx,
  output logic          o_Rx_DV,
  output logic          o_Done,
  output logic [7:0]    o_Xcv_TX_Byte,
  output logic          o_Xcv_TX_DV,
  input  logic          i_Xcv_TX_Ready,
  input  logic          i_Xcv_RX_DV,
  input  logic [7:0]    i_Xcv_RX_Byte,
  output logic          o_SPI_CS_n
);

  localparam logic [LW-1:0] MAX_L = LW'(MAX_BYTES);
  localparam logic [LW-1:0] ONE_L = LW'(1);

  state_t             state_q;
  logic [TMR_W-1:0]   tmr_q;
  logic [LW-1:0]      remain_q;
  logic [LW-1:0]      idx_q;
  logic               cs_n_q;
  logic               busy_q;
  logic               src_ack_q;
  logic [7:0]         tx_byte_q;
  logic               tx_dv_q;
  logic [7:0]         rx_byte_q;
  logic [LW-1:0]      rx_idx_q;
  logic               rx_dv_q;
  logic               done_q;

  // Timing note: each timed state is entered on the same edge that ends the
  // previous phase, and the LOAD/rising-CS edges themselves consume one cycle.
  // SETUP and HOLD therefore last (CLKS-1) cycles and are skipped entirely
  // when CLKS is 1; this gives CS_n fall -> first TX_DV = CS_SETUP_CLKS and
  // last RX_DV -> CS_n rise = CS_HOLD_CLKS. GAP lasts CS_IDLE_CLKS cycles.
  always_ff @(posedge i_Clk or negedge i_Rst_L) begin
    if (!i_Rst_L) begin
      state_q   <= ST_IDLE;
      tmr_q     <= '0;
      remain_q  <= '0;
      idx_q     <= '0;
      cs_n_q    <= 1'b1;
      busy_q    <= 1'b0;
      src_ack_q <= 1'b0;
      tx_byte_q <= 8'h00;
      tx_dv_q   <= 1'b0;
      rx_byte_q <= 8'h00;
      rx_idx_q  <= '0;
      rx_dv_q   <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      // Pulse outputs default low every cycle.
      src_ack_q <= 1'b0;
      tx_dv_q   <= 1'b0;
      rx_dv_q   <= 1'b0;
      done_q    <= 1'b0;

      case (state_q)
        ST_IDLE: begin
          if (i_Start && (i_Len != '0)) begin
            remain_q <= (i_Len > MAX_L) ? MAX_L : i_Len;
            idx_q    <= '0;
            cs_n_q   <= 1'b0;
            busy_q   <= 1'b1;
            if (CS_SETUP_CLKS > 1) begin
              state_q <= ST_SETUP;
              tmr_q   <= tmr_preset(CS_SETUP_CLKS, 2);
            end else begin
              state_q <= ST_LOAD;
            end
          end
        end

        ST_SETUP: begin
          if (tmr_q == '0) begin
            state_q <= ST_LOAD;
          end else begin
            tmr_q <= tmr_q - 1'b1;
          end
        end

        ST_LOAD: begin
          // Stall here (CS_n low, no SPI clocks) until both sides are ready.
          if (i_Src_Valid && i_Xcv_TX_Ready) begin
            tx_byte_q <= i_Src_Byte;
            tx_dv_q   <= 1'b1;
            src_ack_q <= 1'b1;
            state_q   <= ST_XFER;
          end
        end

        ST_XFER: begin
          if (i_Xcv_RX_DV) begin
            rx_byte_q <= i_Xcv_RX_Byte;
            rx_idx_q  <= idx_q;
            rx_dv_q   <= 1'b1;
            if (idx_q != MAX_L) begin
              idx_q <= idx_q + ONE_L;
            end
            if (remain_q != '0) begin
              remain_q <= remain_q - ONE_L;
            end
            if (remain_q <= ONE_L) begin
              if (CS_HOLD_CLKS > 1) begin
                state_q <= ST_HOLD;
                tmr_q   <= tmr_preset(CS_HOLD_CLKS, 2);
              end else begin
                cs_n_q  <= 1'b1;
                done_q  <= 1'b1;
                state_q <= ST_GAP;
                tmr_q   <= tmr_preset(CS_IDLE_CLKS, 1);
              end
            end else begin
              state_q <= ST_LOAD;
            end
          end
        end

        ST_HOLD: begin
          if (tmr_q == '0) begin
            cs_n_q  <= 1'b1;
            done_q  <= 1'b1;
            state_q <= ST_GAP;
            tmr_q   <= tmr_preset(CS_IDLE_CLKS, 1);
          end else begin
            tmr_q <= tmr_q - 1'b1;
          end
        end

        ST_GAP: begin
          if (tmr_q == '0) begin
            busy_q  <= 1'b0;
            state_q <= ST_IDLE;
          end else begin
            tmr_q <= tmr_q - 1'b1;
          end
        end

        default: begin
          cs_n_q  <= 1'b1;
          busy_q  <= 1'b0;
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  assign o_Busy        = busy_q;
  assign o_Src_Ack     = src_ack_q;
  assign o_Rx_Byte     = rx_byte_q;
  assign o_Rx_Idx      = rx_idx_q;
  assign o_Rx_DV       = rx_dv_q;
  assign o_Done        = done_q;
  assign o_Xcv_TX_Byte = tx_byte_q;
  assign o_Xcv_TX_DV   = tx_dv_q;
  assign o_SPI_CS_n    = cs_n_q;

endmodule : spi_cs_sequencer

`default_nettype wire

// File: tb/tb_spi_cs_sequencer.sv
// ============================================================================
// Module   : tb_spi_cs_sequencer
// Purpose  : Self-checking bench for spi_cs_sequencer with a behavioural
//            transceiver, upstream byte source and RX scoreboard.
// Revision : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_spi_cs_sequencer;
  import spi_cs_sequencer_pkg::*;

  localparam int MAXB  = DEF_MAX_BYTES;
  localparam int SETUP = DEF_CS_SETUP_CLKS;
  localparam int HOLD  = DEF_CS_HOLD_CLKS;
  localparam int IDLE  = DEF_CS_IDLE_CLKS;
  localparam int LW    = $clog2(MAXB + 1);
  localparam int XLAT  = 8;   // transceiver cycles per byte

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic [LW-1:0] len = '0;
  logic          busy;
  logic [7:0]    src_byte = 8'h00;
  logic          src_valid = 1'b0;
  logic          src_ack;
  logic [7:0]    rx_byte;
  logic [LW-1:0] rx_idx;
  logic          rx_dv;
  logic          done;
  logic [7:0]    xtx_byte;
  logic          xtx_dv;
  logic          xtx_ready = 1'b1;
  logic          xrx_dv = 1'b0;
  logic [7:0]    xrx_byte = 8'h00;
  logic          cs_n;

  always #5 clk = ~clk;

  spi_cs_sequencer #(
    .MAX_BYTES(MAXB), .CS_SETUP_CLKS(SETUP), .CS_HOLD_CLKS(HOLD), .CS_IDLE_CLKS(IDLE)
  ) dut (
    .i_Clk(clk), .i_Rst_L(rst_n), .i_Start(start), .i_Len(len), .o_Busy(busy),
    .i_Src_Byte(src_byte), .i_Src_Valid(src_valid), .o_Src_Ack(src_ack),
    .o_Rx_Byte(rx_byte), .o_Rx_Idx(rx_idx), .o_Rx_DV(rx_dv), .o_Done(done),
    .o_Xcv_TX_Byte(xtx_byte), .o_Xcv_TX_DV(xtx_dv), .i_Xcv_TX_Ready(xtx_ready),
    .i_Xcv_RX_DV(xrx_dv), .i_Xcv_RX_Byte(xrx_byte), .o_SPI_CS_n(cs_n)
  );

  typedef struct packed {
    logic [7:0]    b;
    logic [LW-1:0] idx;
  } rx_exp_t;

  rx_exp_t    exp_q[$];
  logic [7:0] src_q[$];
  logic [7:0] miso_q[$];

  int chk = 0, pass = 0, cyc = 0;
  int n_dv = 0, n_ack = 0, n_rxdv = 0, n_done = 0, n_cs_fall = 0, n_cs_rise = 0, n_busy_rise = 0;
  int viol_done = 0, viol_ack = 0;
  int t_start = 0, t_cs_fall = 0, t_first_dv = 0, t_cs_rise = 0, t_done = 0, t_busy_fall = 0, t_rx_last = 0;
  bit first_dv_pend = 0;
  logic prev_cs = 1'b1, prev_busy = 1'b0;
  int xcnt = 0;
  logic [7:0] xbyte = 8'h00;
  int stall_at = -1, stall_left = 0, stall_viol = 0;
  bit src_en = 1'b1;

  // Monitor, scoreboard, transceiver model and byte source, all on negedge.
  always @(negedge clk) begin
    rx_exp_t e;
    if (start) t_start = cyc;
    if (!cs_n && prev_cs) begin n_cs_fall++; t_cs_fall = cyc; first_dv_pend = 1; end
    if (cs_n && !prev_cs) begin n_cs_rise++; t_cs_rise = cyc; end
    if (rst_n && (done != (cs_n && !prev_cs))) viol_done++;
    if (busy && !prev_busy) n_busy_rise++;
    if (!busy && prev_busy) t_busy_fall = cyc;
    if (done) begin n_done++; t_done = cyc; end
    if (src_ack != xtx_dv) viol_ack++;
    if (xtx_dv) begin
      n_dv++;
      if (first_dv_pend) begin t_first_dv = cyc; first_dv_pend = 0; end
      chk++;
      if (src_q.size() == 0) $display("FAIL tx_byte: DV with byte %h but source queue empty", xtx_byte);
      else if (xtx_byte !== src_q[0]) $display("FAIL tx_byte: got %h want %h", xtx_byte, src_q[0]);
      else pass++;
    end
    if (src_ack) begin
      n_ack++;
      if (src_q.size() > 0) void'(src_q.pop_front());
    end
    if (rx_dv) begin
      n_rxdv++;
      chk++;
      if (exp_q.size() == 0) $display("FAIL rx_unexpected: got byte %h idx %0d, none expected", rx_byte, rx_idx);
      else begin
        e = exp_q.pop_front();
        if (rx_byte !== e.b || rx_idx !== e.idx)
          $display("FAIL rx_data: got %h/%0d want %h/%0d", rx_byte, rx_idx, e.b, e.idx);
        else pass++;
      end
    end
    prev_cs = cs_n;
    prev_busy = busy;

    // Upstream source stall window, starting once the stall_at-th byte is back.
    if (stall_left > 0 && n_ack == stall_at && n_rxdv == stall_at) begin
      stall_left--;
      if (xtx_dv || cs_n || xcnt != 0) stall_viol++;
      src_en = 1'b0;
    end else begin
      src_en = 1'b1;
    end

    // Transceiver: busy XLAT cycles per byte, RX_DV pulse, then ready again.
    if (!rst_n) begin
      xcnt = 0; xtx_ready = 1'b1; xrx_dv = 1'b0;
    end else begin
      xrx_dv = 1'b0;
      if (xtx_dv) begin
        xtx_ready = 1'b0;
        xcnt = XLAT;
        if (miso_q.size() > 0) xbyte = miso_q.pop_front();
        else xbyte = xtx_byte;
      end else if (xcnt > 0) begin
        xcnt--;
        if (xcnt == 0) begin xrx_dv = 1'b1; xrx_byte = xbyte; t_rx_last = cyc; end
      end else begin
        xtx_ready = 1'b1;
      end
    end

    src_valid = src_en && (src_q.size() > 0);
    src_byte = (src_q.size() > 0) ? src_q[0] : 8'h00;
    cyc++;
  end

  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin @(negedge clk); #1; end
  endtask

  task automatic pulse_start(input int l);
    @(posedge clk); #2;
    start = 1'b1; len = LW'(l);
    @(posedge clk); #2;
    start = 1'b0;
  endtask

  task automatic wait_done(input int d0, input int budget);
    for (int i = 0; i < budget && n_done == d0; i++) begin @(negedge clk); #1; end
  endtask

  task automatic test_reset();
    tick(3);
    chk++; if (cs_n !== 1'b1) $display("FAIL reset_cs: got %b want 1", cs_n); else pass++;
    chk++; if ({busy, src_ack, rx_dv, done, xtx_dv} !== 5'b0)
      $display("FAIL reset_flags: got %b want 00000", {busy, src_ack, rx_dv, done, xtx_dv}); else pass++;
    chk++; if ({rx_byte, xtx_byte, rx_idx} !== '0)
      $display("FAIL reset_data: got %h/%h/%0d want 0", rx_byte, xtx_byte, rx_idx); else pass++;
    @(posedge clk); #2; rst_n = 1'b1;
    tick(2);
  endtask

  task automatic test_single();
    int d0, r0;
    d0 = n_done; r0 = n_rxdv;
    src_q.push_back(8'hA5);
    exp_q.push_back('{b: 8'hA5, idx: LW'(0)});
    pulse_start(1);
    wait_done(d0, 200);
    tick(IDLE + 3);
    chk++; if (t_cs_fall !== t_start + 1) $display("FAIL single_cs_fall: got %0d want %0d", t_cs_fall, t_start + 1); else pass++;
    chk++; if (t_first_dv !== t_start + 1 + SETUP) $display("FAIL single_first_dv: got %0d want %0d", t_first_dv, t_start + 1 + SETUP); else pass++;
    chk++; if (n_rxdv - r0 !== 1) $display("FAIL single_rx_count: got %0d want 1", n_rxdv - r0); else pass++;
    chk++; if (n_done - d0 !== 1) $display("FAIL single_done_count: got %0d want 1", n_done - d0); else pass++;
    chk++; if (t_cs_rise !== t_rx_last + HOLD) $display("FAIL single_hold: got %0d want %0d", t_cs_rise, t_rx_last + HOLD); else pass++;
    chk++; if (t_done !== t_cs_rise) $display("FAIL single_done_at_cs: got %0d want %0d", t_done, t_cs_rise); else pass++;
    chk++; if (t_busy_fall !== t_done + IDLE) $display("FAIL single_idle: got %0d want %0d", t_busy_fall, t_done + IDLE); else pass++;
    chk++; if (exp_q.size() !== 0) $display("FAIL single_leftover: got %0d want 0", exp_q.size()); else pass++;
  endtask

  task automatic test_multi();
    logic [7:0] tx[3];
    logic [7:0] mi[3];
    int d0, v0, a0, r0, f0, u0;
    tx = '{8'h20, 8'h11, 8'h22};
    mi = '{8'h0E, 8'hFF, 8'h00};
    d0 = n_done; v0 = n_dv; a0 = n_ack; r0 = n_rxdv; f0 = n_cs_fall; u0 = n_cs_rise;
    for (int i = 0; i < 3; i++) begin
      src_q.push_back(tx[i]); miso_q.push_back(mi[i]);
      exp_q.push_back('{b: mi[i], idx: LW'(i)});
    end
    pulse_start(3);
    wait_done(d0, 300);
    tick(IDLE + 3);
    chk++; if (n_dv - v0 !== 3 || n_ack - a0 !== 3) $display("FAIL multi_dv_ack: got %0d/%0d want 3/3", n_dv - v0, n_ack - a0); else pass++;
    chk++; if (n_rxdv - r0 !== 3) $display("FAIL multi_rx_count: got %0d want 3", n_rxdv - r0); else pass++;
    chk++; if (n_cs_fall - f0 !== 1 || n_cs_rise - u0 !== 1) $display("FAIL multi_cs_toggle: got %0d/%0d want 1/1", n_cs_fall - f0, n_cs_rise - u0); else pass++;
    chk++; if (n_done - d0 !== 1) $display("FAIL multi_done: got %0d want 1", n_done - d0); else pass++;
    chk++; if (exp_q.size() !== 0 || src_q.size() !== 0) $display("FAIL multi_leftover: got %0d/%0d want 0/0", exp_q.size(), src_q.size()); else pass++;
  endtask

  task automatic test_stall();
    int d0, r0, u0;
    d0 = n_done; r0 = n_rxdv; u0 = n_cs_rise;
    for (int i = 0; i < 3; i++) begin
      src_q.push_back(8'h31 + 8'(i));
      exp_q.push_back('{b: 8'h31 + 8'(i), idx: LW'(i)});
    end
    stall_viol = 0; stall_at = 1 + n_ack; stall_left = 50;
    stall_at = n_ack + 1;
    pulse_start(3);
    wait_done(d0, 600);
    tick(IDLE + 3);
    chk++; if (stall_viol !== 0) $display("FAIL stall_activity: got %0d want 0", stall_viol); else pass++;
    chk++; if (stall_left !== 0) $display("FAIL stall_window: got %0d left want 0", stall_left); else pass++;
    chk++; if (n_rxdv - r0 !== 3 || n_done - d0 !== 1) $display("FAIL stall_complete: got %0d/%0d want 3/1", n_rxdv - r0, n_done - d0); else pass++;
    chk++; if (n_cs_rise - u0 !== 1) $display("FAIL stall_cs_toggle: got %0d want 1", n_cs_rise - u0); else pass++;
    chk++; if (exp_q.size() !== 0) $display("FAIL stall_leftover: got %0d want 0", exp_q.size()); else pass++;
    stall_at = -1;
  endtask

  task automatic test_len_bounds();
    int d0, v0, f0, b0;
    d0 = n_done; f0 = n_cs_fall; b0 = n_busy_rise;
    pulse_start(0);
    tick(20);
    chk++; if (n_cs_fall - f0 !== 0 || n_busy_rise - b0 !== 0 || n_done - d0 !== 0)
      $display("FAIL len0_activity: got %0d/%0d/%0d want 0/0/0", n_cs_fall - f0, n_busy_rise - b0, n_done - d0); else pass++;
    d0 = n_done; v0 = n_dv;
    for (int i = 0; i < 40; i++) begin
      src_q.push_back(8'(i * 3 + 1));
      if (i < MAXB) exp_q.push_back('{b: 8'(i * 3 + 1), idx: LW'(i)});
    end
    pulse_start(40);
    wait_done(d0, 1500);
    tick(IDLE + 3);
    chk++; if (n_dv - v0 !== MAXB) $display("FAIL clamp_bytes: got %0d want %0d", n_dv - v0, MAXB); else pass++;
    chk++; if (n_done - d0 !== 1) $display("FAIL clamp_done: got %0d want 1", n_done - d0); else pass++;
    chk++; if (src_q.size() !== 40 - MAXB) $display("FAIL clamp_src_left: got %0d want %0d", src_q.size(), 40 - MAXB); else pass++;
    chk++; if (exp_q.size() !== 0) $display("FAIL clamp_leftover: got %0d want 0", exp_q.size()); else pass++;
    src_q.delete();
  endtask

  task automatic test_ignore_start();
    int d0, r0, f0, v0;
    d0 = n_done; r0 = n_rxdv; f0 = n_cs_fall; v0 = n_dv;
    src_q.push_back(8'h5A); src_q.push_back(8'hC3);
    miso_q.push_back(8'h01); miso_q.push_back(8'h02);
    exp_q.push_back('{b: 8'h01, idx: LW'(0)});
    exp_q.push_back('{b: 8'h02, idx: LW'(1)});
    pulse_start(2);
    for (int i = 0; i < 100 && n_dv == v0; i++) tick(1);
    pulse_start(5);
    wait_done(d0, 300);
    tick(20);
    chk++; if (n_rxdv - r0 !== 2) $display("FAIL ignore_rx_count: got %0d want 2", n_rxdv - r0); else pass++;
    chk++; if (n_done - d0 !== 1 || n_cs_fall - f0 !== 1) $display("FAIL ignore_txn_count: got %0d/%0d want 1/1", n_done - d0, n_cs_fall - f0); else pass++;
    chk++; if (busy !== 1'b0) $display("FAIL ignore_busy_end: got %b want 0", busy); else pass++;
    chk++; if (exp_q.size() !== 0) $display("FAIL ignore_leftover: got %0d want 0", exp_q.size()); else pass++;
  endtask

  task automatic test_reset_mid();
    int d0, v0, r0;
    d0 = n_done; v0 = n_dv;
    for (int i = 0; i < 3; i++) begin
      src_q.push_back(8'h90 + 8'(i));
      exp_q.push_back('{b: 8'h90 + 8'(i), idx: LW'(i)});
    end
    pulse_start(3);
    for (int i = 0; i < 200 && n_dv - v0 < 2; i++) tick(1);
    tick(3);
    @(posedge clk); #3;
    rst_n = 1'b0;
    #1;
    chk++; if (cs_n !== 1'b1) $display("FAIL rstmid_cs: got %b want 1", cs_n); else pass++;
    chk++; if ({busy, src_ack, rx_dv, done, xtx_dv} !== 5'b0)
      $display("FAIL rstmid_flags: got %b want 00000", {busy, src_ack, rx_dv, done, xtx_dv}); else pass++;
    tick(3);
    chk++; if (n_done - d0 !== 0) $display("FAIL rstmid_no_done: got %0d want 0", n_done - d0); else pass++;
    exp_q.delete(); src_q.delete(); miso_q.delete();
    @(posedge clk); #2; rst_n = 1'b1;
    tick(2);
    d0 = n_done; r0 = n_rxdv;
    src_q.push_back(8'h77); src_q.push_back(8'h88);
    exp_q.push_back('{b: 8'h77, idx: LW'(0)});
    exp_q.push_back('{b: 8'h88, idx: LW'(1)});
    pulse_start(2);
    wait_done(d0, 300);
    tick(IDLE + 3);
    chk++; if (n_rxdv - r0 !== 2 || n_done - d0 !== 1) $display("FAIL rstmid_fresh: got %0d/%0d want 2/1", n_rxdv - r0, n_done - d0); else pass++;
    chk++; if (exp_q.size() !== 0) $display("FAIL rstmid_leftover: got %0d want 0", exp_q.size()); else pass++;
  endtask

  initial begin
    test_reset();
    test_single();
    test_multi();
    test_stall();
    test_len_bounds();
    test_ignore_start();
    test_reset_mid();
    chk++; if (viol_done !== 0) $display("FAIL done_vs_cs_rise: got %0d mismatched cycles want 0", viol_done); else pass++;
    chk++; if (viol_ack !== 0) $display("FAIL ack_vs_dv: got %0d mismatched cycles want 0", viol_ack); else pass++;
    $display("%0d/%0d checks passed", pass, chk);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

endmodule : tb_spi_cs_sequencer

`default_nettype wire
